// File: rtl/decsel_pkg.sv
// Shared types and constants for the decsel select-code sequencer.
package decsel_pkg;

    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic CE_ACTIVE = 1'b0;
    localparam logic CE_IDLE   = 1'b1;

    localparam logic [SEL_W-1:0] SEL_ONE  = {{(SEL_W-1){1'b0}}, 1'b1};
    localparam logic [SEL_W-1:0] SEL_ZERO = {SEL_W{1'b0}};

endpackage

// File: rtl/decsel_step.sv
// Combinational next-code calculation for the select-code sweep.
module decsel_step
    import decsel_pkg::*;
(
    input  logic [SEL_W-1:0] sel_i,
    input  logic [SEL_W-1:0] first_i,
    input  logic [SEL_W-1:0] last_i,
    input  logic             mode_i,
    input  logic             dir_i,
    output logic [SEL_W-1:0] next_o,
    output logic             at_last_o,
    output logic             wrap_to_first_o
);

    // Successor code: restart at first in continuous mode, else step with mod-8 wrap.
    always_comb begin
        at_last_o       = (sel_i == last_i);
        wrap_to_first_o = at_last_o & mode_i;
        next_o          = sel_i;
        if (wrap_to_first_o) begin
            next_o = first_i;
        end else if (dir_i) begin
            next_o = sel_i - SEL_ONE;
        end else begin
            next_o = sel_i + SEL_ONE;
        end
    end

endmodule

// File: rtl/decsel_sequencer.sv
// Select-code sequencer driving the registered 3-to-8 decoder (a/b/c, pol, ce_).
// Define DECSEL_UPDOWN_EN to add the dir input for descending sweeps.
module decsel_sequencer
    import decsel_pkg::*;
#(
    parameter bit AUTOSTEP = 1'b0,
    parameter bit POL_RST  = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [SEL_W-1:0] first,
    input  logic [SEL_W-1:0] last,
    input  logic             step,
    input  logic             pol_in,
`ifdef DECSEL_UPDOWN_EN
    input  logic             dir,
`endif
    output logic [SEL_W-1:0] sel,
    output logic             ce_,
    output logic             pol,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] first_q, first_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic             mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             ce_n_q, ce_n_d;
    logic             pol_q, pol_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             dir_s;
    logic             advance_s;
    logic [SEL_W-1:0] next_s;
    logic             at_last_s;
    logic             wrap_to_first_s;

`ifdef DECSEL_UPDOWN_EN
    assign dir_s = dir;
`else
    assign dir_s = 1'b0;
`endif

    assign advance_s = AUTOSTEP ? 1'b1 : step;

    decsel_step u_step (
        .sel_i           (sel_q),
        .first_i         (first_q),
        .last_i          (last_q),
        .mode_i          (mode_q),
        .dir_i           (dir_q),
        .next_o          (next_s),
        .at_last_o       (at_last_s),
        .wrap_to_first_o (wrap_to_first_s)
    );

    // Next-state and registered-output decode; the strobe defaults to inactive.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        first_d = first_q;
        last_d  = last_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        pol_d   = pol_q;
        busy_d  = busy_q;
        ce_n_d  = CE_IDLE;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    first_d = first;
                    last_d  = last;
                    mode_d  = mode;
                    dir_d   = dir_s;
                    pol_d   = pol_in;
                    sel_d   = first;
                    ce_n_d  = CE_ACTIVE;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            RUN: begin
                if (stop) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (advance_s) begin
                    if (at_last_s && !wrap_to_first_s) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        sel_d   = next_s;
                        ce_n_d  = CE_ACTIVE;
                    end
                end else begin
                    sel_d = sel_q;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            sel_q   <= SEL_ZERO;
            first_q <= SEL_ZERO;
            last_q  <= SEL_ZERO;
            mode_q  <= 1'b0;
            dir_q   <= 1'b0;
            ce_n_q  <= CE_IDLE;
            pol_q   <= POL_RST;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            first_q <= first_d;
            last_q  <= last_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            ce_n_q  <= ce_n_d;
            pol_q   <= pol_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sel  = sel_q;
    assign ce_  = ce_n_q;
    assign pol  = pol_q;
    assign busy = busy_q;
    assign done = done_q;
    assign tc   = busy_q & (sel_q == last_q);

endmodule
